uart_txrx: RTL and testbench
============================

# uart_txrx

Fixed-baud 8N1 UART block: a transmitter that serializes an 8-bit word into continuous back-to-back frames, plus an independent receiver that deserializes frames from a serial line. Used for the 9600 bps serial link from a 250 kHz system clock. Transmit and receive paths share only the clock and reset; loopback is done externally by tying `tx_serial` to `rx_serial`.

## Interface

- `CLKS_PER_BIT`, 26, clock cycles per serial bit (250 kHz / 9600 bps).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `tx_start_bit`  in  1  line level driven during the start-bit period (normally 0).
- `tx_data`  in  8  word to transmit; sampled at frame start.
- `tx_stop_bit`  in  1  line level driven during the stop-bit period (normally 1).
- `tx_active`  out  1  high while a frame (start, data, stop) is on the line.
- `tx_serial`  out  1  serial output; idles high.
- `tx_done`  out  1  one-cycle pulse after each frame completes.
- `rx_serial`  in  1  serial input; idles high.
- `rx_data`  out  8  last received word; held until the next frame completes.
- `rx_done`  out  1  one-cycle pulse when `rx_data` is updated.

## Operation

- Transmitter FSM states: IDLE, START, DATA, STOP.
  - IDLE: exactly one cycle. `tx_serial`=1, `tx_active`=0. Latches `tx_data`, `tx_start_bit`, `tx_stop_bit`. Goes to START.
  - START: drives latched start level for `CLKS_PER_BIT` cycles.
  - DATA: drives latched data bits LSB first (bit 0 to bit 7), each for `CLKS_PER_BIT` cycles; 3-bit bit index, 5-bit cycle counter.
  - STOP: drives latched stop level for `CLKS_PER_BIT` cycles, then goes to IDLE.
- Transmission is continuous: no request input; frames repeat back-to-back for as long as `rst_n` is high.
- Input changes during a frame never affect the frame in progress.
- Receiver:
  - `rx_serial` passes through a 2-flop synchronizer, with both flops reset to 1. All "rx level" references below mean the synchronized level.
  - Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE: waits for rx level 0, then goes to START with the counter cleared.
  - START: after `(CLKS_PER_BIT-1)/2` (=12) further cycles, i.e. mid-bit, re-samples. If 0, goes to DATA. If 1, treats it as a glitch and returns to IDLE with no output.
  - DATA: every `CLKS_PER_BIT` cycles, samples one bit into a shift register, LSB first; after 8 bits goes to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, samples the stop bit (value ignored; no framing-error flag). Loads the shift register into `rx_data`, pulses `rx_done` for one cycle, and returns to IDLE.
- Reset (async, any time, including mid-frame): both FSMs go to IDLE and all counters clear.
  - Reset values: `tx_serial`=1, `tx_active`=0, `tx_done`=0, `rx_data`=8'h00, `rx_done`=0.

## Timing

- Frame on the line: 10 bit times = 260 cycles. Transmit period = 261 cycles (1 IDLE + 260).
- After reset deassertion: first IDLE cycle, then `tx_serial` drops to the start level on the next edge.
- `tx_active` rises with START and falls on the edge entering IDLE.
- `tx_done` is high exactly during the IDLE cycle that follows STOP. It is not asserted in the first IDLE after reset.
- Receiver latency, loopback case: `rx_done` asserts about 2 (synchronizer) + 12 + 8×26 + 26 cycles after the start edge. That is mid-stop-bit, before the transmitter's stop period ends, so the receiver is back in IDLE before the next start edge.
- `rx_data` changes only in the cycle `rx_done` is high.
- Minimum start pulse accepted: at least 13 cycles low. Shorter low pulses produce no `rx_done`.

## Test plan

- Loopback, `tx_data`=8'hD1, start=0, stop=1, run 5 frames:
  - `tx_serial` sequence is 0,1,0,0,0,1,0,1,1,1, each level for 26 cycles.
  - `rx_done` pulses once per frame, 261 cycles apart, with `rx_data`=8'hD1 each time.
  - `tx_done` pulses once per frame.
- Change `tx_data` to 8'h3C in the middle of frame 1: frame 1 still receives 8'hD1, frame 2 receives 8'h3C.
- Drive `rx_serial` low for 8 cycles, then high: no `rx_done`, and the receiver returns to IDLE.
- Assert `rst_n`=0 during DATA:
  - Outputs take reset values immediately (asynchronously): `tx_serial`=1, `tx_active`=0, `rx_data`=8'h00.
  - After release, a full fresh frame is sent and received correctly.
- Set `tx_start_bit`=1: the line stays high throughout, `tx_active` still toggles per frame, and `rx_done` never asserts.
- `tx_data`=8'h00 then 8'hFF: received values match, confirming all-zero and all-one patterns with correct stop-bit handling.

Source files
------------

// File: rtl/uart_txrx.sv
// Fixed-baud 8N1 UART: a free-running transmitter that sends back-to-back frames,
// plus an independent receiver with a 2-flop input synchronizer and mid-bit sampling.
module uart_txrx #(
  parameter int CLKS_PER_BIT = 26
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_start_bit,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_stop_bit,
  output logic       o_tx_active,
  output logic       o_tx_serial,
  output logic       o_tx_done,
  input  logic       i_rx_serial,
  output logic [7:0] o_rx_data,
  output logic       o_rx_done
);

  localparam logic [4:0] LAST_CNT = 5'(CLKS_PER_BIT - 1);
  // Counter reaches this value on the 12th cycle after the falling edge is seen (mid start bit).
  localparam logic [4:0] MID_CNT  = 5'((CLKS_PER_BIT - 1) / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  txState_t   r_txState;
  logic [4:0] r_txCnt;
  logic [2:0] r_txBitIdx;
  logic [7:0] r_txData;
  logic       r_txStop;
  logic [2:0] w_txNextIdx;

  rxState_t   r_rxState;
  logic [4:0] r_rxCnt;
  logic [2:0] r_rxBitIdx;
  logic [7:0] r_rxShift;
  logic [1:0] r_rxSync;
  logic       w_rxLevel;

  assign w_txNextIdx = r_txBitIdx + 3'd1;
  assign w_rxLevel   = r_rxSync[1];

  // The start level goes straight into o_tx_serial, so only data and stop need latching.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_txState   <= TX_IDLE;
      r_txCnt     <= '0;
      r_txBitIdx  <= '0;
      r_txData    <= '0;
      r_txStop    <= 1'b1;
      o_tx_serial <= 1'b1;
      o_tx_active <= 1'b0;
      o_tx_done   <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      case (r_txState)
        TX_IDLE: begin
          r_txData    <= i_tx_data;
          r_txStop    <= i_tx_stop_bit;
          r_txCnt     <= '0;
          r_txBitIdx  <= '0;
          o_tx_serial <= i_tx_start_bit;
          o_tx_active <= 1'b1;
          r_txState   <= TX_START;
        end
        TX_START: begin
          if (r_txCnt == LAST_CNT) begin
            r_txCnt     <= '0;
            o_tx_serial <= r_txData[0];
            r_txState   <= TX_DATA;
          end else begin
            r_txCnt <= r_txCnt + 5'd1;
          end
        end
        TX_DATA: begin
          if (r_txCnt == LAST_CNT) begin
            r_txCnt <= '0;
            if (r_txBitIdx == 3'd7) begin
              o_tx_serial <= r_txStop;
              r_txState   <= TX_STOP;
            end else begin
              r_txBitIdx  <= w_txNextIdx;
              o_tx_serial <= r_txData[w_txNextIdx];
            end
          end else begin
            r_txCnt <= r_txCnt + 5'd1;
          end
        end
        TX_STOP: begin
          if (r_txCnt == LAST_CNT) begin
            r_txCnt     <= '0;
            o_tx_serial <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b1;
            r_txState   <= TX_IDLE;
          end else begin
            r_txCnt <= r_txCnt + 5'd1;
          end
        end
        default: r_txState <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rxSync <= 2'b11;
    end else begin
      r_rxSync <= {r_rxSync[0], i_rx_serial};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rxState  <= RX_IDLE;
      r_rxCnt    <= '0;
      r_rxBitIdx <= '0;
      r_rxShift  <= '0;
      o_rx_data  <= '0;
      o_rx_done  <= 1'b0;
    end else begin
      o_rx_done <= 1'b0;
      case (r_rxState)
        RX_IDLE: begin
          r_rxCnt    <= '0;
          r_rxBitIdx <= '0;
          if (!w_rxLevel) r_rxState <= RX_START;
        end
        RX_START: begin
          if (r_rxCnt == MID_CNT) begin
            r_rxCnt   <= '0;
            r_rxState <= w_rxLevel ? RX_IDLE : RX_DATA;
          end else begin
            r_rxCnt <= r_rxCnt + 5'd1;
          end
        end
        RX_DATA: begin
          if (r_rxCnt == LAST_CNT) begin
            r_rxCnt   <= '0;
            r_rxShift <= {w_rxLevel, r_rxShift[7:1]};
            if (r_rxBitIdx == 3'd7) begin
              r_rxState <= RX_STOP;
            end else begin
              r_rxBitIdx <= r_rxBitIdx + 3'd1;
            end
          end else begin
            r_rxCnt <= r_rxCnt + 5'd1;
          end
        end
        RX_STOP: begin
          if (r_rxCnt == LAST_CNT) begin
            r_rxCnt   <= '0;
            o_rx_data <= r_rxShift;
            o_rx_done <= 1'b1;
            r_rxState <= RX_IDLE;
          end else begin
            r_rxCnt <= r_rxCnt + 5'd1;
          end
        end
        default: r_rxState <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_txrx.sv
// Loopback bench for uart_txrx: a frame-level line model predicts every tx cycle and
// queues expected received words; a monitor pops them whenever rx_done fires.
module tb_uart_txrx;

  localparam int FRAME = 261;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       txStartBit;
  logic       txStopBit;
  logic [7:0] txData;
  logic       rxDrive;
  logic       txActive;
  logic       txSerial;
  logic       txDone;
  logic       rxSerial;
  logic [7:0] rxData;
  logic       rxDone;

  int         vectors = 0;
  int         miscompares = 0;
  int         k = -1;
  logic [7:0] expQ[$];
  logic [7:0] mData = 8'h00;
  logic       mStart = 1'b0;
  logic       mStop = 1'b1;
  logic [7:0] lastRx = 8'h00;

  // Loopback, with rxDrive able to pull the line low to inject glitches.
  assign rxSerial = txSerial & rxDrive;

  always #5 clk = ~clk;

  uart_txrx #(.CLKS_PER_BIT(26)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_tx_start_bit (txStartBit),
    .i_tx_data      (txData),
    .i_tx_stop_bit  (txStopBit),
    .o_tx_active    (txActive),
    .o_tx_serial    (txSerial),
    .o_tx_done      (txDone),
    .i_rx_serial    (rxSerial),
    .o_rx_data      (rxData),
    .o_rx_done      (rxDone)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line level expected at a given position in a 261-cycle frame (0 = idle cycle).
  function automatic logic expLine(input int pos);
    if (pos == 0) return 1'b1;
    if (pos <= 26) return mStart;
    if (pos <= 234) return mData[(pos - 27) / 26];
    return mStop;
  endfunction

  // Each frame samples the inputs on the edge that leaves its idle cycle.
  always @(posedge clk) begin
    if (rst_n) begin
      k = k + 1;
      if (k % FRAME == 0) begin
        mData  = txData;
        mStart = txStartBit;
        mStop  = txStopBit;
        if (!txStartBit) expQ.push_back(txData);
      end
    end
  end

  always @(negedge clk) begin : monitor
    int pos;
    logic [7:0] exp;
    if (rst_n) begin
      pos = (k + 1) % FRAME;
      checkOutput("tx_serial", 32'(txSerial), 32'(expLine(pos)));
      checkOutput("tx_active", 32'(txActive), 32'(pos != 0));
      checkOutput("tx_done", 32'(txDone), 32'(pos == 0 && k >= 0));
      if (rxDone) begin
        if (expQ.size() == 0) begin
          checkOutput("rx_done_unexpected", 32'(rxDone), 32'd0);
        end else begin
          exp = expQ.pop_front();
          checkOutput("rx_data", 32'(rxData), 32'(exp));
          checkOutput("rx_done_in_stop_bit", 32'(pos >= 238 && pos <= 260), 32'd1);
          lastRx = exp;
        end
      end else begin
        checkOutput("rx_data_hold", 32'(rxData), 32'(lastRx));
      end
    end
  end

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitPos(input int p);
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if ((k + 1) % FRAME == p) found = 1'b1;
    end
    if (!found) checkOutput("wait_frame_pos_timeout", 32'd0, 32'd1);
  endtask

  // Asynchronous reset: outputs are checked before any clock edge arrives.
  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    checkOutput("reset_tx_serial", 32'(txSerial), 32'd1);
    checkOutput("reset_tx_active", 32'(txActive), 32'd0);
    checkOutput("reset_tx_done", 32'(txDone), 32'd0);
    checkOutput("reset_rx_data", 32'(rxData), 32'h00);
    checkOutput("reset_rx_done", 32'(rxDone), 32'd0);
    k = -1;
    expQ.delete();
    lastRx = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic startLvl, input int frames);
    txData     = data;
    txStartBit = startLvl;
    runCycles(frames * FRAME);
  endtask

  initial begin
    bit drained;
    txData     = 8'hD1;
    txStartBit = 1'b0;
    txStopBit  = 1'b1;
    rxDrive    = 1'b1;
    #2;
    applyReset();

    applyStimulus(8'hD1, 1'b0, 5);
    waitPos(130);
    txData = 8'h3C;
    runCycles(2 * FRAME);

    applyStimulus(8'h00, 1'b0, 2);
    applyStimulus(8'hFF, 1'b0, 2);

    for (int i = 0; i < 10; i++) begin
      txData = 8'($urandom);
      runCycles($urandom_range(1, 2 * FRAME));
    end

    // Idle-high line (start level 1, all-ones data) so injected glitches are isolated.
    applyStimulus(8'hFF, 1'b1, 3);
    rxDrive = 1'b0;
    runCycles(8);
    rxDrive = 1'b1;
    runCycles(60);
    for (int g = 0; g < 4; g++) begin
      rxDrive = 1'b0;
      runCycles($urandom_range(1, 10));
      rxDrive = 1'b1;
      runCycles(40);
    end
    applyStimulus(8'($urandom), 1'b0, 3);

    waitPos(100);
    #3;
    applyReset();
    applyStimulus(8'($urandom), 1'b0, 3);

    drained = 1'b0;
    for (int i = 0; i < 2 * FRAME && !drained; i++) begin
      @(negedge clk);
      if (expQ.size() == 0) drained = 1'b1;
    end
    checkOutput("rx_queue_drained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
